// File: rtl/deadtime_gen_mc.sv
// deadtime_gen_mc: multi-channel complementary gate driver with independent rise/fall deadtimes,
// per-channel enable masking and a sticky fault shutdown.
module deadtime_gen_mc #(
    parameter int CH = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_i,
    input  logic [CH-1:0] ch_en_i,
    input  logic [CH-1:0] in_pwm_i,
    input  logic [CW-1:0] dead_rise_i,
    input  logic [CW-1:0] dead_fall_i,
    input  logic          fault_i,
    input  logic          fault_clr_i,
    output logic [CH-1:0] pwm_h_o,
    output logic [CH-1:0] pwm_l_o,
    output logic [CH-1:0] dt_active_o,
    output logic          fault_latched_o
);
    typedef enum logic [2:0] {OFF, DT_H, H_ON, DT_L, L_ON} state_t;

    state_t        state_q [CH];
    state_t        state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CH-1:0] pwm_h_q, pwm_l_q, dt_q;
    logic          fault_q;
    logic          run;

    assign run = enable_i & ~fault_q & ~fault_i;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!(run && ch_en_i[i])) begin
                state_d[i] = OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    OFF: begin
                        state_d[i] = in_pwm_i[i] ? DT_H : DT_L;
                        cnt_d[i]   = in_pwm_i[i] ? dead_rise_i : dead_fall_i;
                    end
                    DT_H: begin
                        if (!in_pwm_i[i]) begin
                            state_d[i] = DT_L;
                            cnt_d[i]   = dead_fall_i;
                        end else if (cnt_q[i] == '0) state_d[i] = H_ON;
                        else cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                    H_ON: begin
                        if (!in_pwm_i[i]) begin
                            state_d[i] = DT_L;
                            cnt_d[i]   = dead_fall_i;
                        end
                    end
                    DT_L: begin
                        if (in_pwm_i[i]) begin
                            state_d[i] = DT_H;
                            cnt_d[i]   = dead_rise_i;
                        end else if (cnt_q[i] == '0) state_d[i] = L_ON;
                        else cnt_d[i] = cnt_q[i] - CW'(1);
                    end
                    L_ON: begin
                        if (in_pwm_i[i]) begin
                            state_d[i] = DT_H;
                            cnt_d[i]   = dead_rise_i;
                        end
                    end
                    default: begin
                        state_d[i] = OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // gate outputs are a registered decode of the next state, so turn-off lands on the sampling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= OFF;
                cnt_q[i]   <= '0;
            end
            pwm_h_q <= '0;
            pwm_l_q <= '0;
            dt_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pwm_h_q[i] <= state_d[i] == H_ON;
                pwm_l_q[i] <= state_d[i] == L_ON;
                dt_q[i]    <= state_d[i] == DT_H || state_d[i] == DT_L;
            end
            fault_q <= fault_i | (fault_q & ~fault_clr_i);
        end
    end

    assign pwm_h_o         = pwm_h_q;
    assign pwm_l_o         = pwm_l_q;
    assign dt_active_o     = dt_q;
    assign fault_latched_o = fault_q;
endmodule
